gbe_tx_sync_fifo: RTL and testbench
===================================

Name: gbe_tx_sync_fifo

Overview:
- Single-clock first-word-fall-through (FWFT) FIFO for the GbE UDP transmit path.
- Serves as both the byte-wide packet-data FIFO and the 64-bit control-descriptor FIFO. The control descriptor is {size[15:0], dest_port[15:0], dest_ip[31:0]}.
- Provides a programmable almost-full flag for application back-pressure and an overflow pulse that upstream logic makes sticky.

Parameters:
- DWIDTH, 8, data width in bits. The control-FIFO instance uses 64.
- AWIDTH, 11, address width. Depth is DEPTH = 2**AWIDTH entries.
- PROG_FULL_THRESH, 2032, occupancy at or above which prog_full asserts. Legal range is 1..DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  DWIDTH  write data.
- wr_en  in  1  write request.
- dout  out  DWIDTH  head-of-FIFO data, valid whenever empty=0.
- rd_en  in  1  read (pop) request.
- prog_full  out  1  almost-full flag.
- empty  out  1  FIFO holds no entries.
- overflow  out  1  one-cycle pulse: previous cycle's write was rejected.

Behaviour:
- Storage: DEPTH x DWIDTH array, write pointer wr_ptr, read pointer rd_ptr, occupancy count (AWIDTH+1 bits). Pointers wrap modulo DEPTH.
- Reset (rst=1 at clk edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, prog_full=0, overflow=0. Stored contents are unaffected. Reset mid-operation discards all entries; wr_en/rd_en in a reset cycle are ignored.
- full (internal) = count==DEPTH.
- Write accepted when wr_en=1 and full=0:
  - mem[wr_ptr]<=din; wr_ptr increments.
  - A write while full is dropped, pointers are unchanged, and overflow=1 on the next cycle only.
  - A simultaneous rd_en does not make a full FIFO accept the write.
- Read accepted when rd_en=1 and empty=0: rd_ptr increments. rd_en while empty is ignored, with no error flag.
- Count update:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - unchanged on both or neither.
  - Write+read in the same cycle on an empty FIFO counts only the write, so count becomes 1.
- FWFT output:
  - dout = mem[rd_ptr] read combinationally, so no rd_en is needed to see the head.
  - A word written into an empty FIFO is visible on dout with empty=0 in the cycle after the write edge (1-cycle write-to-visible latency).
  - After an accepted read, dout shows the next entry in the following cycle.
  - dout is don't-care while empty=1.
- Flags:
  - Flags are registered and derived from the post-update count.
  - empty = (count==0).
  - prog_full = (count >= PROG_FULL_THRESH).
  - Both update in the same cycle as count.
- Ordering: strict FIFO with no data loss except rejected writes.

Optional Feature:
- Macro GBE_FIFO_DATA_COUNT_EN.
- When defined: adds output data_count (AWIDTH+1 bits), equal to the registered count, 0 after reset.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle -> empty=1, prog_full=0, overflow=0; rd_en=1 for 3 cycles leaves empty=1.
- Write din=0xA5 once into an empty FIFO (DWIDTH=8) -> the next cycle shows empty=0 and dout=0xA5; pulse rd_en -> the next cycle shows empty=1.
- Write 0x01..0x10, then read 16 times -> dout sequence 0x01..0x10 in order; empty=1 after the last read.
- AWIDTH=4, PROG_FULL_THRESH=12: write 11 words -> prog_full=0. Write the 12th -> prog_full=1 the next cycle. Read 1 -> prog_full=0.
- AWIDTH=4: write 16 words, then a 17th write with din=0xFF -> overflow=1 for exactly one cycle; the 16 stored words read back intact, with 0xFF never appearing.
- Fill 5 words, assert rst for 1 cycle -> empty=1 and prog_full=0 (with the macro, data_count=0); a subsequent write of 0x3C appears on dout as the head.

Source files
------------

// File: rtl/gbe_tx_sync_fifo_if.sv
// Write/read port bundle for gbe_tx_sync_fifo.
// Handshake: a write is taken when wr_en=1 and the FIFO is not full; a read pops when rd_en=1 and empty=0.
interface gbe_tx_sync_fifo_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] din;
  logic              wr_en;
  logic [DWIDTH-1:0] dout;
  logic              rd_en;
  logic              prog_full;
  logic              empty;
  logic              overflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, prog_full, empty, overflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, prog_full, empty, overflow
  );
endinterface

// File: rtl/gbe_tx_sync_fifo.sv
// Single-clock FWFT FIFO for the GbE UDP TX path (payload bytes and 64-bit descriptors).
// Optional macro GBE_FIFO_DATA_COUNT_EN adds the data_count occupancy output.
module gbe_tx_sync_fifo #(
  parameter int DWIDTH           = 8,
  parameter int AWIDTH           = 11,
  parameter int PROG_FULL_THRESH = 2032
) (
  input  logic              clk,
  input  logic              rst,
`ifdef GBE_FIFO_DATA_COUNT_EN
  output logic [AWIDTH:0]   data_count,
`endif
  gbe_tx_sync_fifo_if.slave fifo_if
);

  localparam int             DEPTH    = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] THRESH_C = (AWIDTH+1)'(PROG_FULL_THRESH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              empty_q, prog_full_q, overflow_q;
  logic              full, wr_accept, rd_accept;

  assign full      = (count_q == DEPTH_C);
  assign wr_accept = fifo_if.wr_en & ~full;
  assign rd_accept = fifo_if.rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    // Simultaneous accepted read and write leave occupancy unchanged.
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      prog_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= (count_d == '0);
      prog_full_q <= (count_d >= THRESH_C);
      overflow_q  <= fifo_if.wr_en & full;
    end
  end

  // Storage is not cleared by reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem_q[wr_ptr_q] <= fifo_if.din;
  end

  assign fifo_if.dout      = mem_q[rd_ptr_q];
  assign fifo_if.empty     = empty_q;
  assign fifo_if.prog_full = prog_full_q;
  assign fifo_if.overflow  = overflow_q;

`ifdef GBE_FIFO_DATA_COUNT_EN
  assign data_count = count_q;
`endif

endmodule

// File: tb/tb_gbe_tx_sync_fifo.sv
// Directed bench for gbe_tx_sync_fifo (DWIDTH=8, AWIDTH=4, PROG_FULL_THRESH=12) with a pop-side scoreboard.
module tb_gbe_tx_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   model_cnt;
  logic [DW-1:0] exp_q[$];

`ifdef GBE_FIFO_DATA_COUNT_EN
  logic [AW:0] data_count;
`endif

  gbe_tx_sync_fifo_if #(.DWIDTH(DW)) fifo_if ();

  gbe_tx_sync_fifo #(
    .DWIDTH(DW),
    .AWIDTH(AW),
    .PROG_FULL_THRESH(12)
  ) u_dut (
    .clk(clk),
    .rst(rst),
`ifdef GBE_FIFO_DATA_COUNT_EN
    .data_count(data_count),
`endif
    .fifo_if(fifo_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_write(input logic [DW-1:0] d);
    fifo_if.din   = d;
    fifo_if.wr_en = 1'b1;
    if (model_cnt < DEPTH) begin
      exp_q.push_back(d);
      model_cnt++;
    end
    cycle();
    fifo_if.wr_en = 1'b0;
  endtask

  task automatic do_read();
    fifo_if.rd_en = 1'b1;
    if (model_cnt > 0) model_cnt--;
    cycle();
    fifo_if.rd_en = 1'b0;
  endtask

  task automatic do_rw(input logic [DW-1:0] d);
    logic acc_w, acc_r;
    acc_w = (model_cnt < DEPTH);
    acc_r = (model_cnt > 0);
    fifo_if.din   = d;
    fifo_if.wr_en = 1'b1;
    fifo_if.rd_en = 1'b1;
    if (acc_w) begin
      exp_q.push_back(d);
      model_cnt++;
    end
    if (acc_r) model_cnt--;
    cycle();
    fifo_if.wr_en = 1'b0;
    fifo_if.rd_en = 1'b0;
  endtask

  // scoreboard monitor: a pop happens at the next edge when rd_en=1 and empty=0
  always @(negedge clk) begin
    if (!rst && fifo_if.rd_en && !fifo_if.empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_underflow: actual=dout 0x%0h required=no pop", fifo_if.dout);
      end else begin
        check("dout", 32'(fifo_if.dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    model_cnt     = 0;
    rst           = 1'b1;
    fifo_if.din   = '0;
    fifo_if.wr_en = 1'b0;
    fifo_if.rd_en = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;

    // reset state and reads while empty
    check("rst_empty", 32'(fifo_if.empty), 32'd1);
    check("rst_prog_full", 32'(fifo_if.prog_full), 32'd0);
    check("rst_overflow", 32'(fifo_if.overflow), 32'd0);
`ifdef GBE_FIFO_DATA_COUNT_EN
    check("rst_data_count", 32'(data_count), 32'd0);
`endif
    fifo_if.rd_en = 1'b1;
    cycle(); cycle(); cycle();
    fifo_if.rd_en = 1'b0;
    check("empty_after_idle_reads", 32'(fifo_if.empty), 32'd1);

    // single word write-to-visible latency
    do_write(8'hA5);
    check("single_empty", 32'(fifo_if.empty), 32'd0);
    check("single_head", 32'(fifo_if.dout), 32'hA5);
    do_read();
    check("single_empty_after_read", 32'(fifo_if.empty), 32'd1);

    // fill completely, overflow attempt, drain in order
    for (int i = 1; i <= 16; i++) do_write(DW'(i));
    check("full_prog_full", 32'(fifo_if.prog_full), 32'd1);
`ifdef GBE_FIFO_DATA_COUNT_EN
    check("full_data_count", 32'(data_count), 32'd16);
`endif
    do_write(8'hFF);
    check("overflow_pulse", 32'(fifo_if.overflow), 32'd1);
    cycle();
    check("overflow_cleared", 32'(fifo_if.overflow), 32'd0);
    check("head_after_overflow", 32'(fifo_if.dout), 32'h01);
    for (int i = 0; i < 16; i++) do_read();
    check("drained_empty", 32'(fifo_if.empty), 32'd1);
    check("drained_prog_full", 32'(fifo_if.prog_full), 32'd0);

    // prog_full threshold crossing
    for (int i = 0; i < 11; i++) do_write(DW'(8'h40 + i));
    check("pf_at_11", 32'(fifo_if.prog_full), 32'd0);
    do_write(8'h4B);
    check("pf_at_12", 32'(fifo_if.prog_full), 32'd1);
    do_read();
    check("pf_after_read", 32'(fifo_if.prog_full), 32'd0);
    for (int i = 0; i < 11; i++) do_read();
    check("pf_drained_empty", 32'(fifo_if.empty), 32'd1);

    // write+read on empty counts only the write
    do_rw(8'h5A);
    check("rw_empty_not_empty", 32'(fifo_if.empty), 32'd0);
    check("rw_empty_head", 32'(fifo_if.dout), 32'h5A);
    do_read();
    check("rw_empty_drained", 32'(fifo_if.empty), 32'd1);

    // write+read on full: write rejected, read still pops
    for (int i = 0; i < 16; i++) do_write(DW'(8'h20 + i));
    do_rw(8'hEE);
    check("rw_full_overflow", 32'(fifo_if.overflow), 32'd1);
    check("rw_full_head", 32'(fifo_if.dout), 32'h21);
    for (int i = 0; i < 15; i++) do_read();
    check("rw_full_drained", 32'(fifo_if.empty), 32'd1);

    // reset mid-operation discards contents
    for (int i = 0; i < 5; i++) do_write(DW'(8'h60 + i));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    check("midrst_empty", 32'(fifo_if.empty), 32'd1);
    check("midrst_prog_full", 32'(fifo_if.prog_full), 32'd0);
`ifdef GBE_FIFO_DATA_COUNT_EN
    check("midrst_data_count", 32'(data_count), 32'd0);
`endif
    do_write(8'h3C);
    check("post_rst_head", 32'(fifo_if.dout), 32'h3C);
    check("post_rst_not_empty", 32'(fifo_if.empty), 32'd0);
    do_read();
    check("post_rst_drained", 32'(fifo_if.empty), 32'd1);

    cycle();
    check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
